fpu_requester: RTL and testbench
================================

// Module: fpu_requester
// PURPOSE
//   Initiator side of the FPU operand/result handshake. Accepts one command
//   (operation + two operands) from the CPU-side valid/ready port and drives
//   the fpu input_rdy/input_ack and output_rdy/output_ack exchange. Returns the
//   result with classification flags on a valid/ready response port.
//   One operation is in flight at a time.
// PARAMETERS
//   WIDTH           32   operand/result width (IEEE-754 single)
//   OP_WIDTH        4    operation code width (4'b0000 add, 4'b0010 mul, 4'b0011 div)
//   TIMEOUT_CYCLES  256  watchdog limit per handshake phase (used only with FPU_TIMEOUT_EN)
// PORTS
//   clock           in   1         single clock, rising edge
//   reset           in   1         asynchronous, active-low
//   cmd_valid       in   1         command present
//   cmd_ready       out  1         command accepted when valid&ready
//   cmd_op          in   OP_WIDTH  operation code
//   cmd_a           in   WIDTH     left operand
//   cmd_b           in   WIDTH     right operand
//   rsp_valid       out  1         response present
//   rsp_ready       in   1         response consumed when valid&ready
//   rsp_result      out  WIDTH     fpu result
//   rsp_flags       out  3         {is_nan, is_inf, is_zero} of rsp_result
//   rsp_timeout     out  1         watchdog fired for this response
//   busy            out  1         state != IDLE
//   fpu_operation   out  OP_WIDTH  to fpu.operation
//   fpu_data_a      out  WIDTH     to fpu.data_a
//   fpu_data_b      out  WIDTH     to fpu.data_b
//   fpu_input_rdy   out  1         to fpu.input_rdy
//   fpu_input_ack   in   1         from fpu.input_ack
//   fpu_output_rdy  in   1         from fpu.output_rdy
//   fpu_output_ack  out  1         to fpu.output_ack
//   fpu_result      in   WIDTH     from fpu.result
// BEHAVIOUR
//   - Reset (reset=0, async): state=IDLE. All outputs 0 except cmd_ready, which is 1 after reset release. Operand registers cleared.
//   - IDLE: cmd_ready=1. On cmd_valid, latch op/a/b and go to ISSUE.
//   - ISSUE (1 cycle after accept): fpu_input_rdy=1. Operands and operation are
//     held stable until fpu_input_ack=1 is sampled. Then drop input_rdy and go to WAIT.
//   - WAIT: on fpu_output_rdy=1, capture fpu_result into rsp_result. Assert
//     fpu_output_ack=1 and go to ACK.
//   - ACK: hold fpu_output_ack=1 until fpu_output_rdy=0 (four-phase), then drop
//     it, set rsp_valid=1 and go to RESP.
//   - input_ack and output_rdy sampled high together in ISSUE: take ISSUE->WAIT
//     only; the result is captured in WAIT on the next cycle.
//   - RESP: rsp_valid=1 and rsp_result/flags/timeout held stable until rsp_ready. On
//     handshake, clear rsp_valid and go to IDLE. cmd_ready=1 again next cycle.
//   - Flags are computed from the captured result:
//     - is_nan: exp=8'hFF and frac!=0
//     - is_inf: exp=8'hFF and frac==0
//     - is_zero: exp==0 and frac==0
//   - Minimum latency: cmd accept -> rsp_valid = 3 + fpu latency cycles.
//   - cmd_ready=0 in every state except IDLE, so back-to-back commands stall.
//   - Reset mid-operation: immediate return to IDLE. Any in-flight fpu transaction is abandoned; the fpu is reset alongside.
// CONFIGURATION
//   FPU_TIMEOUT_EN defined:
//     - 16-bit phase counter runs in ISSUE, WAIT and ACK. It clears on every state change.
//     - When the counter reaches TIMEOUT_CYCLES, drop fpu_input_rdy and fpu_output_ack.
//     - Load rsp_result=32'hFFFFFFFF (NaN, flags=3'b100) and rsp_timeout=1, then go to RESP.
//   FPU_TIMEOUT_EN undefined: no counter; rsp_timeout tied 0; a hung fpu stalls forever.
// TESTING
//   1. Model fpu acks after 2 cycles and gives output_rdy 3 cycles later.
//      cmd op=0, a=32'h3F800000, b=32'h40000000 -> fpu result 32'h40400000.
//      Expect rsp_result 32'h40400000, flags 000, and operands stable while input_rdy=1.
//   2. Model fpu returns 32'hFFFFFFFF -> flags 100; return 32'h7F800000 -> flags 010;
//      return 32'h80000000 -> flags 001.
//   3. Hold rsp_ready=0 for 5 cycles -> rsp_valid and rsp_result stay stable and cmd_ready
//      stays 0. Raise rsp_ready -> IDLE and cmd_ready=1 next cycle.
//   4. Model fpu keeps output_rdy high 4 cycles after output_ack -> output_ack held 4 cycles.
//      Expect no second capture and exactly one response.
//   5. Assert reset during WAIT -> fpu_input_rdy, fpu_output_ack, rsp_valid and busy are 0
//      at once. After release cmd_ready=1; a new command then completes normally.
//   6. (FPU_TIMEOUT_EN, TIMEOUT_CYCLES=16) fpu never asserts input_ack.
//      Expect rsp_valid 17 cycles after ISSUE entry, with rsp_result 32'hFFFFFFFF and rsp_timeout=1.

Source files
------------

// File: rtl/fpu_requester.sv
// -----------------------------------------------------------------------------
// fpu_requester
//   Initiator side of the FPU operand/result handshake. Takes one command
//   (operation plus two operands) from a CPU-side valid/ready port. It then
//   runs the four-phase input_rdy/input_ack and output_rdy/output_ack exchange
//   with the FPU. The captured result and its classification flags are
//   returned on a valid/ready response port. Only one operation is in flight
//   at a time.
//
// Build option
//   FPU_TIMEOUT_EN : enables a per-phase watchdog. If an FPU handshake phase
//                    lasts TIMEOUT_CYCLES cycles, the exchange is abandoned.
//                    The response then carries an all-ones NaN with
//                    rsp_timeout_o=1. Without this macro there is no
//                    watchdog, rsp_timeout_o is 0, and a hung FPU stalls.
//
// Ports
//   clk_i, rst_ni        clock (rising edge), asynchronous active-low reset
//   cmd_valid_i/ready_o  command handshake; cmd_op_i, cmd_a_i, cmd_b_i payload
//   rsp_valid_o/ready_i  response handshake; rsp_result_o, rsp_flags_o
//                        {is_nan,is_inf,is_zero}, rsp_timeout_o
//   busy_o               high whenever the requester is not idle
//   fpu_operation_o, fpu_data_a_o, fpu_data_b_o   operands driven to the FPU
//   fpu_input_rdy_o / fpu_input_ack_i             operand handshake
//   fpu_output_rdy_i / fpu_output_ack_o           result handshake
//   fpu_result_i                                  result from the FPU
// -----------------------------------------------------------------------------
module fpu_requester #(
  parameter int WIDTH          = 32,
  parameter int OP_WIDTH       = 4,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                cmd_valid_i,
  output logic                cmd_ready_o,
  input  logic [OP_WIDTH-1:0] cmd_op_i,
  input  logic [WIDTH-1:0]    cmd_a_i,
  input  logic [WIDTH-1:0]    cmd_b_i,
  output logic                rsp_valid_o,
  input  logic                rsp_ready_i,
  output logic [WIDTH-1:0]    rsp_result_o,
  output logic [2:0]          rsp_flags_o,
  output logic                rsp_timeout_o,
  output logic                busy_o,
  output logic [OP_WIDTH-1:0] fpu_operation_o,
  output logic [WIDTH-1:0]    fpu_data_a_o,
  output logic [WIDTH-1:0]    fpu_data_b_o,
  output logic                fpu_input_rdy_o,
  input  logic                fpu_input_ack_i,
  input  logic                fpu_output_rdy_i,
  output logic                fpu_output_ack_o,
  input  logic [WIDTH-1:0]    fpu_result_i
);

  localparam int EXP_W  = 8;
  localparam int FRAC_W = WIDTH - 1 - EXP_W;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_ACK,
    S_RESP
  } state_e;

  state_e                state_q, state_d;
  logic                  ready_en_q;   // holds cmd_ready low until the first edge after reset
  logic [OP_WIDTH-1:0]   op_q;
  logic [WIDTH-1:0]      a_q, b_q;
  logic [WIDTH-1:0]      result_q;
  logic [2:0]            flags_q;
  logic                  accept;
  logic                  capture;
  logic                  input_rdy;
  logic                  output_ack;

  // {is_nan, is_inf, is_zero} for an IEEE-754 value; the sign is ignored.
  function automatic logic [2:0] classify(input logic [WIDTH-1:0] v);
    logic exp_ones;
    logic exp_zero;
    logic frac_zero;
    exp_ones  = &v[WIDTH-2 -: EXP_W];
    exp_zero  = ~|v[WIDTH-2 -: EXP_W];
    frac_zero = ~|v[FRAC_W-1:0];
    return {exp_ones & ~frac_zero, exp_ones & frac_zero, exp_zero & frac_zero};
  endfunction

`ifdef FPU_TIMEOUT_EN
  logic [15:0] cnt_q, cnt_d;
  logic        timeout_q;
  logic        in_phase;
  logic        timeout_hit;

  assign in_phase    = (state_q == S_ISSUE) || (state_q == S_WAIT) || (state_q == S_ACK);
  assign timeout_hit = in_phase && (cnt_q == 16'(TIMEOUT_CYCLES));
`endif

  // Next-state and handshake outputs.
  always_comb begin
    state_d    = state_q;
    accept     = 1'b0;
    capture    = 1'b0;
    input_rdy  = 1'b0;
    output_ack = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (cmd_valid_i && ready_en_q) begin
          accept  = 1'b1;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        input_rdy = 1'b1;
        // A simultaneous output_rdy is deliberately ignored here; WAIT
        // picks it up on the following cycle.
        if (fpu_input_ack_i) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (fpu_output_rdy_i) begin
          capture = 1'b1;
          state_d = S_ACK;
        end
      end
      S_ACK: begin
        // Four-phase: ack stays up until the FPU withdraws output_rdy.
        output_ack = 1'b1;
        if (!fpu_output_rdy_i) begin
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        if (rsp_ready_i) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
`ifdef FPU_TIMEOUT_EN
    // The watchdog overrides any handshake progress in the same cycle.
    if (timeout_hit) begin
      capture    = 1'b0;
      input_rdy  = 1'b0;
      output_ack = 1'b0;
      state_d    = S_RESP;
    end
`endif
  end

`ifdef FPU_TIMEOUT_EN
  // Phase counter restarts on every state change.
  always_comb begin
    cnt_d = 16'd0;
    if (in_phase && (state_d == state_q)) begin
      cnt_d = cnt_q + 16'd1;
    end
  end
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= S_IDLE;
      ready_en_q <= 1'b0;
      op_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      result_q   <= '0;
      flags_q    <= 3'b000;
`ifdef FPU_TIMEOUT_EN
      cnt_q      <= 16'd0;
      timeout_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      ready_en_q <= 1'b1;
      if (accept) begin
        op_q <= cmd_op_i;
        a_q  <= cmd_a_i;
        b_q  <= cmd_b_i;
`ifdef FPU_TIMEOUT_EN
        timeout_q <= 1'b0;
`endif
      end
      if (capture) begin
        result_q <= fpu_result_i;
        flags_q  <= classify(fpu_result_i);
      end
`ifdef FPU_TIMEOUT_EN
      cnt_q <= cnt_d;
      if (timeout_hit) begin
        result_q  <= {WIDTH{1'b1}};
        flags_q   <= classify({WIDTH{1'b1}});
        timeout_q <= 1'b1;
      end
`endif
    end
  end

  assign cmd_ready_o      = (state_q == S_IDLE) && ready_en_q;
  assign busy_o           = (state_q != S_IDLE);
  assign rsp_valid_o      = (state_q == S_RESP);
  assign rsp_result_o     = result_q;
  assign rsp_flags_o      = flags_q;
  assign fpu_operation_o  = op_q;
  assign fpu_data_a_o     = a_q;
  assign fpu_data_b_o     = b_q;
  assign fpu_input_rdy_o  = input_rdy;
  assign fpu_output_ack_o = output_ack;
`ifdef FPU_TIMEOUT_EN
  assign rsp_timeout_o    = timeout_q;
`else
  assign rsp_timeout_o    = 1'b0;
`endif

endmodule

// File: tb/tb_fpu_requester.sv
// -----------------------------------------------------------------------------
// tb_fpu_requester
//   Self-checking bench for fpu_requester. A cycle-based FPU responder model
//   answers the handshake with per-job latencies. Every issued command pushes
//   its expected response into a scoreboard queue. A monitor on the falling
//   edge pops and compares each response handshake.
// -----------------------------------------------------------------------------
module tb_fpu_requester;

  localparam int F_IDLE = 0, F_ACKDLY = 1, F_ACKHOLD = 2, F_OUTDLY = 3,
                 F_OUTRDY = 4, F_HOLD = 5, F_DROP = 6;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    int          ack_dly;
    int          out_dly;
    int          hold;
    bit          early;
  } job_t;

  typedef struct {
    logic [31:0] res;
    logic [2:0]  flags;
    bit          to;
  } exp_t;

  logic        clk, rst_n;
  logic        cmd_valid, cmd_ready;
  logic [3:0]  cmd_op;
  logic [31:0] cmd_a, cmd_b;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_result;
  logic [2:0]  rsp_flags;
  logic        rsp_timeout, busy;
  logic [3:0]  fpu_operation;
  logic [31:0] fpu_data_a, fpu_data_b, fpu_result;
  logic        fpu_input_rdy, fpu_input_ack, fpu_output_rdy, fpu_output_ack;

  int   errors = 0;
  int   checks = 0;
  int   n_expected = 0;
  int   n_resp = 0;
  int   rdy_force = 0;   // 0 random, 1 hold low, 2 hold high
  int   fm_state;
  int   fm_cnt;
  job_t cur;
  job_t job_q[$];
  exp_t exp_q[$];

  fpu_requester #(.WIDTH(32), .OP_WIDTH(4), .TIMEOUT_CYCLES(16)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
    .cmd_op_i(cmd_op), .cmd_a_i(cmd_a), .cmd_b_i(cmd_b),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
    .rsp_result_o(rsp_result), .rsp_flags_o(rsp_flags),
    .rsp_timeout_o(rsp_timeout), .busy_o(busy),
    .fpu_operation_o(fpu_operation), .fpu_data_a_o(fpu_data_a), .fpu_data_b_o(fpu_data_b),
    .fpu_input_rdy_o(fpu_input_rdy), .fpu_input_ack_i(fpu_input_ack),
    .fpu_output_rdy_i(fpu_output_rdy), .fpu_output_ack_o(fpu_output_ack),
    .fpu_result_i(fpu_result)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic bound_expired(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got timeout expected event", name);
  endtask

  // Reference classification from the IEEE-754 field rules.
  function automatic logic [2:0] ref_flags(input logic [31:0] r);
    int unsigned e;
    int unsigned f;
    e = (r >> 23) % 256;
    f = r % (1 << 23);
    return {(e == 255) && (f != 0), (e == 255) && (f == 0), (e == 0) && (f == 0)};
  endfunction

  function automatic logic [31:0] mk_fp(input int unsigned s, input int unsigned e, input int unsigned f);
    return 32'((s << 31) + (e << 23) + f);
  endfunction

  // ---------------- response ready driver ----------------
  initial begin
    rsp_ready = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      if (rdy_force == 0) rsp_ready = ($urandom_range(0, 2) != 0);
      else if (rdy_force == 1) rsp_ready = 1'b0;
      else rsp_ready = 1'b1;
    end
  end

  // ---------------- scoreboard monitor ----------------
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && rsp_valid && rsp_ready) begin
        n_resp++;
        if (exp_q.size() == 0) begin
          bound_expired("unexpected_rsp");
        end else begin
          e = exp_q.pop_front();
          chk("rsp_result", rsp_result, e.res);
          chk("rsp_flags", 32'(rsp_flags), 32'(e.flags));
          chk("rsp_timeout", 32'(rsp_timeout), 32'(e.to));
          $display("rsp %0d: result=%08h flags=%03b timeout=%0b", n_resp, rsp_result, rsp_flags, rsp_timeout);
        end
      end
    end
  end

  // ---------------- FPU responder model ----------------
  task automatic chk_operands();
    chk("fpu_operation", 32'(fpu_operation), 32'(cur.op));
    chk("fpu_data_a", fpu_data_a, cur.a);
    chk("fpu_data_b", fpu_data_b, cur.b);
  endtask

  task automatic model_raise_ack();
    fpu_input_ack = 1'b1;
    if (cur.early) begin
      fpu_output_rdy = 1'b1;
      fpu_result     = cur.res;
    end
    fm_state = F_ACKHOLD;
  endtask

  initial begin
    fm_state = F_IDLE;
    fm_cnt = 0;
    fpu_input_ack = 1'b0;
    fpu_output_rdy = 1'b0;
    fpu_result = 32'h0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        fm_state = F_IDLE;
        fpu_input_ack = 1'b0;
        fpu_output_rdy = 1'b0;
      end else begin
        case (fm_state)
          F_IDLE: if (fpu_input_rdy) begin
            if (job_q.size() == 0) begin
              bound_expired("fpu_job_missing");
            end else begin
              cur = job_q.pop_front();
              chk_operands();
              if (cur.ack_dly == 0) model_raise_ack();
              else begin
                fm_cnt = cur.ack_dly;
                fm_state = F_ACKDLY;
              end
            end
          end
          F_ACKDLY: begin
            if (!fpu_input_rdy) fm_state = F_IDLE;  // abandoned by the watchdog
            else begin
              chk_operands();
              fm_cnt--;
              if (fm_cnt == 0) model_raise_ack();
            end
          end
          F_ACKHOLD: begin
            if (fpu_input_rdy) chk_operands();
            else begin
              fpu_input_ack = 1'b0;
              if (cur.early) fm_state = F_OUTRDY;
              else begin
                fpu_result = $urandom;  // junk must not be captured
                if (cur.out_dly == 0) begin
                  fpu_output_rdy = 1'b1;
                  fpu_result = cur.res;
                  fm_state = F_OUTRDY;
                end else begin
                  fm_cnt = cur.out_dly;
                  fm_state = F_OUTDLY;
                end
              end
            end
          end
          F_OUTDLY: begin
            fm_cnt--;
            if (fm_cnt == 0) begin
              fpu_output_rdy = 1'b1;
              fpu_result = cur.res;
              fm_state = F_OUTRDY;
            end
          end
          F_OUTRDY: if (fpu_output_ack) begin
            fpu_result = ~cur.res;  // a second capture would be visible
            if (cur.hold == 0) begin
              fpu_output_rdy = 1'b0;
              fm_state = F_DROP;
            end else begin
              fm_cnt = cur.hold;
              fm_state = F_HOLD;
            end
          end
          F_HOLD: begin
            chk("output_ack_held", 32'(fpu_output_ack), 32'd1);
            fm_cnt--;
            if (fm_cnt == 0) begin
              fpu_output_rdy = 1'b0;
              fm_state = F_DROP;
            end
          end
          F_DROP: if (!fpu_output_ack) fm_state = F_IDLE;
          default: fm_state = F_IDLE;
        endcase
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic issue(input job_t j, input bit to_exp);
    exp_t e;
    int   n;
    n = 0;
    while (!cmd_ready && n < 500) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!cmd_ready) begin
      bound_expired("cmd_ready_wait");
      return;
    end
    cmd_valid = 1'b1;
    cmd_op = j.op;
    cmd_a = j.a;
    cmd_b = j.b;
    e.res = to_exp ? 32'hFFFFFFFF : j.res;
    e.flags = ref_flags(e.res);
    e.to = to_exp;
    job_q.push_back(j);
    exp_q.push_back(e);
    n_expected++;
    $display("cmd: op=%0d a=%08h b=%08h fpu_res=%08h", j.op, j.a, j.b, j.res);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || !cmd_ready) && n < 2000) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (exp_q.size() != 0 || !cmd_ready) bound_expired("drain");
  endtask

  function automatic job_t mk_job(input logic [31:0] a, input logic [31:0] b, input logic [31:0] res);
    job_t j;
    j.op = 4'd0; j.a = a; j.b = b; j.res = res;
    j.ack_dly = 2; j.out_dly = 3; j.hold = 0; j.early = 1'b0;
    return j;
  endfunction

  initial begin
    job_t        j;
    logic [31:0] held;
    int          k;
    logic [31:0] specials[3];
    specials[0] = 32'hFFFFFFFF;
    specials[1] = 32'h7F800000;
    specials[2] = 32'h80000000;

    rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = 4'd0; cmd_a = 32'd0; cmd_b = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_input_rdy", 32'(fpu_input_rdy), 32'd0);
    chk("rst_output_ack", 32'(fpu_output_ack), 32'd0);
    chk("rst_rsp_result", rsp_result, 32'd0);
    chk("rst_rsp_flags", 32'(rsp_flags), 32'd0);
    chk("rst_rsp_timeout", 32'(rsp_timeout), 32'd0);
    chk("rst_fpu_data_a", fpu_data_a, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_cmd_ready", 32'(cmd_ready), 32'd1);

    // 1.0 + 2.0 = 3.0 with ack after 2 cycles, result 3 cycles later
    issue(mk_job(32'h3F800000, 32'h40000000, 32'h40400000), 1'b0);
    drain();

    // special-value classification
    for (int i = 0; i < 3; i++) begin
      issue(mk_job($urandom, $urandom, specials[i]), 1'b0);
      drain();
    end

    // response back-pressure
    rdy_force = 1;
    issue(mk_job(32'h40A00000, 32'h3F000000, 32'h40B00000), 1'b0);
    k = 0;
    while (!rsp_valid && k < 200) begin @(posedge clk); #1; k++; end
    if (!rsp_valid) bound_expired("bp_rsp_valid");
    held = rsp_result;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk("bp_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("bp_rsp_result", rsp_result, held);
      chk("bp_cmd_ready", 32'(cmd_ready), 32'd0);
    end
    rdy_force = 2;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    chk("bp_release_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("bp_release_rsp_valid", 32'(rsp_valid), 32'd0);
    rdy_force = 0;
    drain();

    // output_rdy held 4 cycles after output_ack
    j = mk_job(32'h41200000, 32'h40000000, 32'h41A00000);
    j.hold = 4;
    issue(j, 1'b0);
    drain();

    // input_ack and output_rdy together
    j = mk_job(32'h3F800000, 32'h3F800000, 32'h00000000);
    j.ack_dly = 1;
    j.early = 1'b1;
    issue(j, 1'b0);
    drain();

    // reset while waiting for the result
    j = mk_job(32'h12345678, 32'h9ABCDEF0, 32'h3F800000);
    j.out_dly = 30;
    issue(j, 1'b0);
    k = 0;
    while (fm_state != F_OUTDLY && k < 100) begin @(posedge clk); #1; k++; end
    if (fm_state != F_OUTDLY) bound_expired("reset_wait_phase");
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_input_rdy", 32'(fpu_input_rdy), 32'd0);
    chk("midrst_output_ack", 32'(fpu_output_ack), 32'd0);
    chk("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    n_expected -= exp_q.size();
    exp_q.delete();
    job_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_cmd_ready", 32'(cmd_ready), 32'd1);
    issue(mk_job(32'h40400000, 32'h40400000, 32'h41100000), 1'b0);
    drain();

`ifdef FPU_TIMEOUT_EN
    // FPU never acknowledges the operands
    j = mk_job(32'h11111111, 32'h22222222, 32'h33333333);
    j.ack_dly = 1000;
    rdy_force = 1;
    issue(j, 1'b1);
    k = 0;
    while (!rsp_valid && k < 100) begin @(posedge clk); #1; k++; end
    chk("timeout_latency", 32'(k), 32'd17);
    rdy_force = 0;
    drain();
`endif

    // randomized traffic
    for (int i = 0; i < 40; i++) begin
      int unsigned sel;
      j.op = (i % 3 == 0) ? 4'd0 : ((i % 3 == 1) ? 4'd2 : 4'd3);
      j.a = $urandom;
      j.b = $urandom;
      j.ack_dly = $urandom_range(0, 4);
      j.out_dly = $urandom_range(0, 5);
      j.hold = $urandom_range(0, 4);
      j.early = ($urandom_range(0, 3) == 0);
      sel = $urandom_range(0, 5);
      case (sel)
        0: j.res = mk_fp($urandom_range(0, 1), 255, $urandom_range(1, (1 << 23) - 1));
        1: j.res = mk_fp($urandom_range(0, 1), 255, 0);
        2: j.res = mk_fp($urandom_range(0, 1), 0, 0);
        3: j.res = mk_fp($urandom_range(0, 1), 0, $urandom_range(1, (1 << 23) - 1));
        default: j.res = $urandom;
      endcase
      issue(j, 1'b0);
    end
    drain();

    chk("rsp_count", 32'(n_resp), 32'(n_expected));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "simulation time limit");
  end

endmodule
